// File: rtl/serial_adder_seq_if.sv
// ---------------------------------------------------------------------------
// serial_adder_seq_if
// Request/result bundle for the serial adder sequencer.
//
// Handshake: the master raises `start` together with `a`, `b` and `cin`.
// The request is taken on the first rising edge where the sequencer is idle
// and `start` is high. While `busy` is high, further requests are ignored and
// are not queued. `done` pulses for exactly one cycle when `sum`/`cout` hold
// the finished result. Those values stay stable until the next accepted
// request reaches its LOAD cycle.
//
//   start  master->slave  request to begin an addition
//   a, b   master->slave  N-bit operands
//   cin    master->slave  carry-in
//   sum    slave->master  N-bit parallel sum
//   cout   slave->master  final carry-out
//   busy   slave->master  addition in progress (LOAD or SHIFT)
//   done   slave->master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface serial_adder_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done
    );
endinterface

// File: rtl/serial_adder_seq.sv
// ---------------------------------------------------------------------------
// serial_adder_seq
// This module sequences operands for a bit-serial adder. It captures two
// N-bit operands and a carry-in, then initialises an external carry flop with
// the carry-in. It then feeds one operand bit per clock, LSB first. Each sum
// bit and each next-carry value is computed from the flop's current value.
// The module builds the parallel sum and the carry-out, then pulses `done`.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-high reset
//   bus        serial_adder_seq_if slave: start/a/b/cin in, sum/cout/busy/done out
//   carry_q    current value of the external carry flop
//   carry_load load strobe for the carry flop (high in LOAD)
//   carry_init value loaded into the carry flop (captured cin)
//   carry_d    next carry for the flop (equals carry_q outside SHIFT)
//   fsm_state  current FSM state, for observation
// ---------------------------------------------------------------------------
module serial_adder_seq #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_seq_if.slave  bus,
    input  logic               carry_q,
    output logic               carry_load,
    output logic               carry_init,
    output logic               carry_d,
    output logic [1:0]         fsm_state
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          cin_reg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sum_reg;
    logic          cout_reg;

    logic          abit;
    logic          bbit;
    logic          sbit;
    logic          maj;
    logic [N-1:0]  sum_next;

    // Full-adder slice on the current LSBs and the external carry.
    always_comb begin
        abit = a_reg[0];
        bbit = b_reg[0];
        sbit = abit ^ bbit ^ carry_q;
        maj  = (abit & bbit) | (abit & carry_q) | (bbit & carry_q);
        // The new sum bit enters at the MSB. After N shifts, bit 0 of the
        // sum has reached position 0. This form also works when N == 1.
        sum_next        = sum_reg >> 1;
        sum_next[N-1]   = sbit;
    end

    // Outside SHIFT, the flop's d input mirrors its q, so the flop holds.
    always_comb begin
        carry_load = (state == LOAD);
        carry_init = (state == LOAD) ? cin_reg : 1'b0;
        carry_d    = (state == SHIFT) ? maj : carry_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            cin_reg  <= 1'b0;
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        cin_reg <= bus.cin;
                        cnt     <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    sum_reg <= sum_next;
                    cnt     <= cnt + CW'(1);
                    // The final bit still shifts in on this edge. The carry
                    // out of the MSB slice becomes cout.
                    if (cnt == CW'(N - 1)) begin
                        cout_reg <= maj;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum   = sum_reg;
    assign bus.cout  = cout_reg;
    assign bus.busy  = (state == LOAD) || (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign fsm_state = state;
endmodule

// File: tb/tb_serial_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_seq
// This is a directed, table-driven bench for serial_adder_seq with N = 8.
// It models the external carry flop. The bench checks:
//   - result values and the carry sequence,
//   - latency and busy/done timing,
//   - start being ignored while busy,
//   - asynchronous reset in the middle of a shift,
//   - back-to-back operation with start held high.
// ---------------------------------------------------------------------------
module tb_serial_adder_seq;
    localparam int N = 8;
    localparam logic [1:0] IDLE = 2'd0;

    logic       clk;
    logic       rst;
    logic       carry_q;
    logic       carry_load;
    logic       carry_init;
    logic       carry_d;
    logic [1:0] fsm_state;

    int checks;
    int errors;

    logic [N:0] exp_q[$];

    serial_adder_seq_if #(.N(N)) bus ();

    serial_adder_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .carry_q    (carry_q),
        .carry_load (carry_load),
        .carry_init (carry_init),
        .carry_d    (carry_d),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset / carry flop ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             carry_q <= 1'b0;
        else if (carry_load) carry_q <= carry_init;
        else                 carry_q <= carry_d;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[10];

    // Run one addition from IDLE. If poke is set, the bench re-asserts start
    // with different operands in the middle of SHIFT. That request must be
    // ignored.
    task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic poke, input logic [N-1:0] exp_sum, input logic exp_cout);
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [N-1:0] got_sum;
        logic got_cout;
        logic c;
        logic exp_d;
        busy_cnt = 0; done_cnt = 0; done_at = -1; got_sum = '0; got_cout = 1'b0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;                       // E0 accepted -> LOAD
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.cin = ~cin;   // later changes must not matter
        check("load_strobe", {31'd0, carry_load}, 32'd1);
        check("load_init", {31'd0, carry_init}, {31'd0, cin});
        if (bus.busy) busy_cnt++;
        c = cin;
        for (int k = 1; k <= N + 2; k++) begin
            @(posedge clk); #1;
            if (poke && k == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF;
            end
            if (poke && k == 6) bus.start = 1'b0;
            if (k <= N) begin
                exp_d = (a[k-1] & b[k-1]) | (a[k-1] & c) | (b[k-1] & c);
                check($sformatf("carry_d_bit%0d", k - 1), {31'd0, carry_d}, {31'd0, exp_d});
                c = exp_d;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at  = k;
                got_sum  = bus.sum;
                got_cout = bus.cout;
            end
        end
        check("sum", {24'd0, got_sum}, {24'd0, exp_sum});
        check("cout", {31'd0, got_cout}, {31'd0, exp_cout});
        check("done_latency", done_at, N + 1);
        check("done_pulses", done_cnt, 1);
        check("busy_cycles", busy_cnt, N + 1);
        check("idle_after", {30'd0, fsm_state}, {30'd0, IDLE});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int done_cnt;
        int done_at;
        checks = 0;
        errors = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[9] = '{8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_load", {31'd0, carry_load}, 32'd0);
        check("rst_init", {31'd0, carry_init}, 32'd0);
        check("rst_d_eq_q", {31'd0, carry_d}, {31'd0, carry_q});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        foreach (vecs[i])
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout);

        // Start while busy must be ignored
        run_add(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("poke_no_relaunch", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset after 4 SHIFT cycles
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;                       // E0
        bus.start = 1'b0;
        repeat (5) @(posedge clk);                // E1 (LOAD->SHIFT), E2..E5 shifts
        #2;
        check("mid_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_sum", {24'd0, bus.sum}, 32'd0);
        check("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        run_add(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

        // Back-to-back with start held high, random operands
        bus.start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic         rc;
            logic [N:0]   exp_v;
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            bus.a = ra; bus.b = rb; bus.cin = rc;
            exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc});
            @(posedge clk); #1;                   // accepting edge
            bus.a = N'($urandom_range(0, 255));
            bus.b = N'($urandom_range(0, 255));
            done_cnt = 0;
            done_at  = -1;
            for (int k = 1; k <= N + 2; k++) begin
                @(posedge clk); #1;
                if (bus.done) begin
                    done_cnt++;
                    done_at = k;
                    if (exp_q.size() > 0) begin
                        exp_v = exp_q.pop_front();
                        check("b2b_result", {23'd0, bus.cout, bus.sum}, {23'd0, exp_v});
                    end
                end
            end
            check("b2b_done_pulses", done_cnt, 1);
            check("b2b_done_latency", done_at, N + 1);
        end
        bus.start = 1'b0;
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
